// File: rtl/wb_port_if.sv
// Bus bundle for the register-file write-back port arbiter: ALU and load
// producers, the registered write port, and the hazard lookup.
interface wb_port_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;

    logic              mem_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;

    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              wb_sel;

    logic [ADDR_W-1:0] haz_addr;
    logic              haz_hit;
    logic [CNT_W-1:0]  q_count;

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  mem_valid, mem_addr, mem_data,
        input  haz_addr,
        output alu_ready, rf_we, rf_waddr, rf_wdata, wb_sel, haz_hit, q_count
    );

    modport master (
        output alu_valid, alu_addr, alu_data,
        output mem_valid, mem_addr, mem_data,
        output haz_addr,
        input  alu_ready, rf_we, rf_waddr, rf_wdata, wb_sel, haz_hit, q_count
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: loads always win the single register-file write
// port, stalled ALU results wait in a small in-order queue, and a lookup
// tells the hazard unit whether a register still has a write pending.
module wb_port_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    wb_port_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] Q_EMPTY = 2'd0;
    localparam logic [1:0] Q_PART  = 2'd1;
    localparam logic [1:0] Q_FULL  = 2'd2;

    logic [ADDR_W-1:0] q_addr [DEPTH];
    logic [DATA_W-1:0] q_data [DEPTH];
    logic [DEPTH-1:0]  slot_vld;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [1:0]        q_state;

    logic accept;
    logic alu_zero;
    logic grant_q;
    logic grant_byp;
    logic enq;
    logic deq;
    logic q_match;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Classify queue occupancy from the registered count.
    always_comb begin
        if (count == '0)
            q_state = Q_EMPTY;
        else if (count == CNT_W'(DEPTH))
            q_state = Q_FULL;
        else
            q_state = Q_PART;
    end

    // Ready depends only on registered occupancy, so a dequeue out of FULL
    // raises it one cycle later. Register-0 ALU results are accepted and dropped.
    assign bus.alu_ready = (q_state != Q_FULL) && rst_n;
    assign accept        = bus.alu_valid && bus.alu_ready;
    assign alu_zero      = (bus.alu_addr == '0);
    assign grant_q       = !bus.mem_valid && (q_state != Q_EMPTY);
    assign grant_byp     = !bus.mem_valid && (q_state == Q_EMPTY) && accept && !alu_zero;
    assign enq           = accept && !alu_zero && !grant_byp;
    assign deq           = grant_q;
    assign bus.q_count   = count;

    // Queue control: pointers, occupancy count and per-slot valid flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            slot_vld <= '0;
        end else begin
            if (deq)
                rd_ptr <= ptr_inc(rd_ptr);
            if (enq)
                wr_ptr <= ptr_inc(wr_ptr);
            if (enq && !deq)
                count <= count + 1'b1;
            else if (deq && !enq)
                count <= count - 1'b1;
            if (deq)
                slot_vld[rd_ptr] <= 1'b0;
            if (enq)
                slot_vld[wr_ptr] <= 1'b1;
        end
    end

    // Queue payload storage; validity is tracked by slot_vld, so no reset.
    always_ff @(posedge clk) begin
        if (enq) begin
            q_addr[wr_ptr] <= bus.alu_addr;
            q_data[wr_ptr] <= bus.alu_data;
        end
    end

    // Registered write port: load first, then queue head, then ALU bypass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rf_we    <= 1'b0;
            bus.rf_waddr <= '0;
            bus.rf_wdata <= '0;
            bus.wb_sel   <= 1'b0;
        end else if (bus.mem_valid) begin
            bus.rf_we    <= (bus.mem_addr != '0);
            bus.rf_waddr <= bus.mem_addr;
            bus.rf_wdata <= bus.mem_data;
            bus.wb_sel   <= 1'b1;
        end else if (grant_q) begin
            bus.rf_we    <= 1'b1;
            bus.rf_waddr <= q_addr[rd_ptr];
            bus.rf_wdata <= q_data[rd_ptr];
            bus.wb_sel   <= 1'b0;
        end else if (grant_byp) begin
            bus.rf_we    <= 1'b1;
            bus.rf_waddr <= bus.alu_addr;
            bus.rf_wdata <= bus.alu_data;
            bus.wb_sel   <= 1'b0;
        end else begin
            bus.rf_we    <= 1'b0;
        end
    end

    // Search occupied queue slots for the address under hazard check.
    always_comb begin
        q_match = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_vld[i] && (q_addr[i] == bus.haz_addr))
                q_match = 1'b1;
        end
    end

    assign bus.haz_hit = (bus.haz_addr != '0) &&
                         (q_match || (bus.rf_we && (bus.rf_waddr == bus.haz_addr)));

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: reset, bypass, collision, backpressure,
// register-0 suppression, hazard lookup and reset with entries queued.
module tb_wb_port_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    wb_port_if #(.DATA_W(32), .ADDR_W(5), .DEPTH(2)) bus ();

    wb_port_arbiter #(.DATA_W(32), .ADDR_W(5), .DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.alu_valid = 1'b0;
        bus.alu_addr  = '0;
        bus.alu_data  = '0;
        bus.mem_valid = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_data  = '0;
    endtask

    task automatic chk_wr(input string tag, input logic we, input logic [4:0] a,
                          input logic [31:0] d, input logic sel);
        chk({tag, "_we"},    32'(bus.rf_we),    32'(we));
        chk({tag, "_waddr"}, 32'(bus.rf_waddr), 32'(a));
        chk({tag, "_wdata"}, bus.rf_wdata,      d);
        chk({tag, "_sel"},   32'(bus.wb_sel),   32'(sel));
    endtask

    task automatic set_mem(input logic v, input logic [4:0] a, input logic [31:0] d);
        bus.mem_valid = v;
        bus.mem_addr  = a;
        bus.mem_data  = d;
    endtask

    task automatic set_alu(input logic v, input logic [4:0] a, input logic [31:0] d);
        bus.alu_valid = v;
        bus.alu_addr  = a;
        bus.alu_data  = d;
    endtask

    initial begin
        idle_inputs();
        bus.haz_addr = '0;

        // Reset state
        repeat (2) tick();
        chk_wr("rst", 1'b0, 5'd0, 32'h0, 1'b0);
        chk("rst_qcount", 32'(bus.q_count), 32'd0);
        chk("rst_ready",  32'(bus.alu_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_ready", 32'(bus.alu_ready), 32'd1);

        // Bypass on idle port
        set_alu(1'b1, 5'd8, 32'h1234);
        tick();
        idle_inputs();
        chk_wr("byp", 1'b1, 5'd8, 32'h1234, 1'b0);
        chk("byp_qcount", 32'(bus.q_count), 32'd0);
        tick();
        chk_wr("byp_hold", 1'b0, 5'd8, 32'h1234, 1'b0);

        // Collision: load wins, ALU queued then written
        set_mem(1'b1, 5'd9, 32'hAAAA);
        set_alu(1'b1, 5'd10, 32'hBBBB);
        tick();
        idle_inputs();
        bus.haz_addr = 5'd10;
        #1;
        chk_wr("col1", 1'b1, 5'd9, 32'hAAAA, 1'b1);
        chk("col1_qcount", 32'(bus.q_count), 32'd1);
        chk("col1_haz_q",  32'(bus.haz_hit), 32'd1);
        tick();
        chk_wr("col2", 1'b1, 5'd10, 32'hBBBB, 1'b0);
        chk("col2_qcount",  32'(bus.q_count), 32'd0);
        chk("col2_haz_inf", 32'(bus.haz_hit), 32'd1);
        tick();
        chk("col3_we",  32'(bus.rf_we),   32'd0);
        chk("col3_haz", 32'(bus.haz_hit), 32'd0);
        bus.haz_addr = '0;

        // Backpressure under continuous loads
        set_mem(1'b1, 5'd21, 32'h2100);
        set_alu(1'b1, 5'd1, 32'h11);
        #1 chk("bp_rdy_a", 32'(bus.alu_ready), 32'd1);
        tick();
        chk_wr("bp_m21", 1'b1, 5'd21, 32'h2100, 1'b1);
        chk("bp_q_a", 32'(bus.q_count), 32'd1);
        set_mem(1'b1, 5'd22, 32'h2200);
        set_alu(1'b1, 5'd2, 32'h22);
        #1 chk("bp_rdy_b", 32'(bus.alu_ready), 32'd1);
        tick();
        chk_wr("bp_m22", 1'b1, 5'd22, 32'h2200, 1'b1);
        chk("bp_q_b", 32'(bus.q_count), 32'd2);
        set_mem(1'b1, 5'd23, 32'h2300);
        set_alu(1'b1, 5'd3, 32'h33);
        #1 chk("bp_rdy_c", 32'(bus.alu_ready), 32'd0);
        tick();
        chk_wr("bp_m23", 1'b1, 5'd23, 32'h2300, 1'b1);
        chk("bp_q_c", 32'(bus.q_count), 32'd2);
        set_mem(1'b1, 5'd24, 32'h2400);
        #1 chk("bp_rdy_d", 32'(bus.alu_ready), 32'd0);
        tick();
        chk_wr("bp_m24", 1'b1, 5'd24, 32'h2400, 1'b1);
        chk("bp_q_d", 32'(bus.q_count), 32'd2);
        set_mem(1'b0, 5'd0, 32'h0);
        #1 chk("bp_rdy_e", 32'(bus.alu_ready), 32'd0);
        tick();
        chk_wr("bp_r1", 1'b1, 5'd1, 32'h11, 1'b0);
        chk("bp_q_e", 32'(bus.q_count), 32'd1);
        #1 chk("bp_rdy_f", 32'(bus.alu_ready), 32'd1);
        tick();
        idle_inputs();
        chk_wr("bp_r2", 1'b1, 5'd2, 32'h22, 1'b0);
        chk("bp_q_f", 32'(bus.q_count), 32'd1);
        tick();
        chk_wr("bp_r3", 1'b1, 5'd3, 32'h33, 1'b0);
        chk("bp_q_g", 32'(bus.q_count), 32'd0);
        tick();
        chk("bp_idle_we", 32'(bus.rf_we), 32'd0);

        // Register 0 from both producers, then ALU r0 alone
        set_mem(1'b1, 5'd0, 32'hDEAD);
        set_alu(1'b1, 5'd0, 32'hBEEF);
        tick();
        idle_inputs();
        chk("r0_we",     32'(bus.rf_we),   32'd0);
        chk("r0_qcount", 32'(bus.q_count), 32'd0);
        chk("r0_haz",    32'(bus.haz_hit), 32'd0);
        set_alu(1'b1, 5'd0, 32'h5555);
        tick();
        idle_inputs();
        chk("r0_alu_we", 32'(bus.rf_we),   32'd0);
        chk("r0_alu_q",  32'(bus.q_count), 32'd0);

        // Hazard lookup with r12 queued behind a load to r5
        set_mem(1'b1, 5'd5, 32'h5050);
        set_alu(1'b1, 5'd12, 32'hC0C0);
        tick();
        idle_inputs();
        bus.haz_addr = 5'd12;
        #1 chk("haz12_q", 32'(bus.haz_hit), 32'd1);
        bus.haz_addr = 5'd13;
        #1 chk("haz13", 32'(bus.haz_hit), 32'd0);
        bus.haz_addr = 5'd5;
        #1 chk("haz5_inf", 32'(bus.haz_hit), 32'd1);
        bus.haz_addr = 5'd12;
        tick();
        chk_wr("haz_r12", 1'b1, 5'd12, 32'hC0C0, 1'b0);
        tick();
        chk("haz12_done", 32'(bus.haz_hit), 32'd0);
        bus.haz_addr = '0;

        // Reset with two entries queued
        set_mem(1'b1, 5'd30, 32'h3000);
        set_alu(1'b1, 5'd6, 32'h66);
        tick();
        set_mem(1'b1, 5'd31, 32'h3100);
        set_alu(1'b1, 5'd7, 32'h77);
        tick();
        idle_inputs();
        chk("mrst_pre_q", 32'(bus.q_count), 32'd2);
        rst_n = 1'b0;
        #1;
        chk_wr("mrst", 1'b0, 5'd0, 32'h0, 1'b0);
        chk("mrst_q",     32'(bus.q_count),   32'd0);
        chk("mrst_ready", 32'(bus.alu_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("mrst_rel_ready", 32'(bus.alu_ready), 32'd1);
        chk("mrst_rel_q",     32'(bus.q_count),   32'd0);
        tick();
        chk("mrst_stale1", 32'(bus.rf_we), 32'd0);
        tick();
        chk("mrst_stale2", 32'(bus.rf_we), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Write-back port arbiter for the register file. Two producers share the single register-file write port: the ALU result path, which can be stalled, and the data-memory load-return path, which cannot. The block grants the port each cycle and buffers stalled ALU results in a small in-order queue. It drives the registered write enable, address, data and the MemtoReg-style source select (`wb_sel`) seen by the write-back mux. It also gives the hazard unit an "address pending" lookup.

## Interface
- `DATA_W`, 32, data width of a register write.
- `ADDR_W`, 5, register address width.
- `DEPTH`, 2, ALU holding-queue depth; legal range is 1 to 4.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `alu_valid` input 1: ALU result is offered this cycle.
- `alu_ready` output 1: ALU result will be accepted at the next edge.
- `alu_addr` input ADDR_W: destination register of the ALU result.
- `alu_data` input DATA_W: ALU result value.
- `mem_valid` input 1: load data is returning this cycle. It has no ready and must always be taken.
- `mem_addr` input ADDR_W: destination register of the load.
- `mem_data` input DATA_W: load data.
- `rf_we` output 1: registered write enable to the register file.
- `rf_waddr` output ADDR_W: registered write address.
- `rf_wdata` output DATA_W: registered write data.
- `wb_sel` output 1: registered source of the current write; 0 = ALU, 1 = memory.
- `haz_addr` input ADDR_W: address being checked by the hazard unit.
- `haz_hit` output 1: combinational; 1 when `haz_addr` ≠ 0 and matches a queued ALU entry or an in-flight `rf_waddr` with `rf_we` = 1.
- `q_count` output clog2(DEPTH+1): current number of queued ALU entries.

## Operation
- **Queue:** a circular buffer of DEPTH entries {addr, data}, with read/write pointers and a count. Queue state is EMPTY (count 0), PART (0 < count < DEPTH) or FULL (count = DEPTH).
- **Ready:** `alu_ready` = (count < DEPTH) && `rst_n`. It depends only on registered count, not on `mem_valid`.
- **Accept:** an ALU result is accepted when `alu_valid` && `alu_ready` at the edge.
- **Grant priority each cycle, highest first:**
  1. `mem_valid`: the load is written.
  2. count > 0: the queue head is written and dequeued.
  3. Accepted ALU result with count = 0: written directly, bypassing the queue.
- **Enqueue:** an accepted ALU result that is not granted is enqueued at the tail.
  - Enqueue and dequeue may occur in the same cycle; count is then unchanged.
  - When FULL, a dequeue frees a slot, but `alu_ready` only rises on the following cycle.
- **Register 0:** any write with address 0 is a no-op.
  - For ALU, the result is accepted and dropped without enqueue.
  - For memory, it consumes the grant with `rf_we` = 0.
  - Neither case sets `haz_hit`.
- **Ordering:**
  - ALU results retire in acceptance order.
  - No ordering between memory and ALU writes is enforced here; the hazard unit uses `haz_hit` to stall.
- **Pointers:** wrap modulo DEPTH. Count never exceeds DEPTH and never goes below 0.

## Timing
- **Latency:** every write appears on the `rf_*` / `wb_sel` outputs one cycle after the granting edge input; the register file commits on the following edge.
  - Bypassed ALU result: latency 1.
  - Queued ALU result: latency 1 + cycles spent queued.
- **Idle cycle:** when nothing is granted, `rf_we` = 0 and `rf_waddr` / `rf_wdata` / `wb_sel` hold their previous values.
- **Reset values:**
  - `rf_we` = 0, `rf_waddr` = 0, `rf_wdata` = 0, `wb_sel` = 0.
  - count = 0, pointers = 0, `q_count` = 0.
  - `alu_ready` = 0 while `rst_n` is low.
- **Reset mid-operation:** queued entries are discarded with no write issued. `alu_ready` returns to 1 on the first cycle with `rst_n` high.
- **Continuous `mem_valid`:** ALU is starved; the queue fills to DEPTH and then `alu_ready` = 0 until `mem_valid` drops.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-stream with 2 entries queued → all outputs 0 immediately; after release, `q_count` = 0 and no stale write appears.
- **Bypass:** `alu_valid` with addr 8, data 0x1234 on an idle port → next cycle `rf_we` = 1, `rf_waddr` = 8, `rf_wdata` = 0x1234, `wb_sel` = 0.
- **Collision:** same cycle `mem_valid` (addr 9, 0xAAAA) and ALU (addr 10, 0xBBBB) → cycle +1 writes r9 with `wb_sel` = 1; cycle +2 writes r10 with `wb_sel` = 0.
- **Backpressure:** `mem_valid` held 4 cycles while ALU offers r1, r2, r3 → `alu_ready` drops after 2 accepts; r3 is held by the source. After `mem_valid` drops, r1, r2, r3 are written in order on consecutive cycles.
- **Register 0:** ALU addr 0 and memory addr 0 → no `rf_we` pulse, `haz_hit` = 0, queue unchanged.
- **Hazard lookup:** with r12 queued, `haz_addr` = 12 → `haz_hit` = 1; `haz_addr` = 13 → `haz_hit` = 0; after r12 retires → `haz_hit` = 0.
